wram_arbiter: RTL and testbench
===============================

Name: wram_arbiter

Overview:
- Owns the single-port 128 KB work-RAM BRAM and shares it between two requesters: the console (A-bus/B-bus access, gated by cpu_en) and a host/debug DMA port used for save-state dump/load and memory inspection.
- The console always has absolute priority.
- Host transfers are block bursts with auto-incrementing address, fed through valid/ready streams, and use only the cycles the console leaves free.

Parameters:
- ADDR_W, 17, RAM address width; depth is 2^ADDR_W bytes.
- RFIFO_DEPTH, 2, host read-return FIFO entries (power of two, >= 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cpu_en  in  1  console timeslot enable.
- con_req  in  1  console accesses RAM this cycle (already-decoded WRAM hit or B-bus WMDATA).
- con_write  in  1  console access is a write.
- con_addr  in  ADDR_W  console address (already A/B muxed).
- con_wdata  in  8  console write data.
- con_rdata  out  8  console read data.
- host_start  in  1  single-cycle command strobe.
- host_dir  in  1  0 = write to RAM, 1 = read from RAM.
- host_addr  in  ADDR_W  burst base address.
- host_len  in  ADDR_W+1  byte count, 0..2^ADDR_W.
- host_abort  in  1  cancel the current burst.
- host_wdata  in  8  write stream data.
- host_wvalid  in  1  write stream valid.
- host_wready  out  1  write stream ready.
- host_rdata  out  8  read stream data.
- host_rvalid  out  1  read stream valid.
- host_rready  in  1  read stream ready.
- host_busy  out  1  burst in progress.
- host_done  out  1  one-cycle pulse when a burst completes.
- ram_addr  out  ADDR_W  BRAM address.
- ram_wdata  out  8  BRAM write data.
- ram_wren  out  1  BRAM write enable.
- ram_q  in  8  BRAM read data, registered, 1-cycle latency.

Behaviour:
- con_gnt = cpu_en & con_req (combinational). When con_gnt is 1, ram_addr = con_addr, ram_wdata = con_wdata, ram_wren = con_write. No host access occurs that cycle.
- When con_gnt is 0, ram_* is driven by the host engine. When the host engine is idle: ram_addr = last host pointer, ram_wren = 0.
- Console read data:
  - A console read granted in cycle N sets con_rd_pend for cycle N+1.
  - In N+1, con_rdata = ram_q (pass-through), and the hold register loads ram_q at the end of N+1.
  - Otherwise con_rdata = hold register.
  - Console writes do not change con_rdata.
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE, host_start = 1:
  - Latch ptr <= host_addr and rem <= host_len.
  - If host_len = 0, go to DONE.
  - Otherwise go to WRITE (host_dir = 0) or READ (host_dir = 1).
- host_start is ignored outside IDLE.
- WRITE:
  - host_wready = !con_gnt.
  - Fire = host_wvalid & host_wready: ram_wren = 1, ram_addr = ptr, ram_wdata = host_wdata; ptr++ (wraps modulo 2^ADDR_W); rem--.
  - When rem reaches 0 on a fire, go to DONE.
- READ:
  - Issue a read when !con_gnt and (fifo_count + inflight) < RFIFO_DEPTH: ram_addr = ptr, ptr++, rem--, inflight set.
  - Returned ram_q is pushed into the FIFO the next cycle.
  - When rem = 0 after an issue, go to DRAIN.
- DRAIN: stay until inflight = 0 and the FIFO is empty, then go to DONE.
- Read FIFO:
  - host_rvalid = FIFO not empty; host_rdata = FIFO head.
  - Pop on host_rvalid & host_rready.
  - Push and pop in the same cycle are both allowed.
  - The FIFO cannot overflow, by the issue rule above.
- DONE: host_done = 1 for exactly one cycle, then IDLE.
- host_busy = 1 in WRITE, READ and DRAIN; 0 in IDLE and DONE.
- host_abort, in any non-IDLE state: go to IDLE next cycle, flush the FIFO, drop the inflight read, no host_done pulse. Writes already performed stay in RAM.
- The console is never stalled or delayed by host activity.
- Reset:
  - State = IDLE; ptr, rem, FIFO and inflight cleared.
  - Outputs: con_rdata = 0, host_wready = 0, host_rvalid = 0, host_rdata = 0, host_busy = 0, host_done = 0, ram_wren = 0, ram_addr = 0, ram_wdata = 0.
  - Reset mid-burst behaves identically to this.

Test Plan:
- Console read of 0x00123 with BRAM preloaded to 0x5A, cpu_en = 1 -> con_rdata = 0x5A in cycle N+1, and still 0x5A 5 cycles later with no further reads.
- Host write of 4 bytes at 0x01000 (AA, BB, CC, DD), host_wvalid held high, con_req with cpu_en on every 2nd cycle -> host_wready = 0 on each console cycle, RAM holds AA..DD at 0x01000-0x01003, host_done pulses once, console accesses still land at the correct addresses.
- Host read of 6 bytes at 0x1FFFE, with host_rready toggling 1/0 -> stream returns bytes from 0x1FFFE, 0x1FFFF, 0x00000..0x00003 in order; no loss or duplication; FIFO never exceeds 2 entries.
- host_start with host_len = 0 -> host_done the next cycle, host_busy never asserted, no RAM write.
- host_abort in READ with 1 read inflight and 1 FIFO entry -> IDLE next cycle, host_rvalid = 0, no host_done. A following host_start is accepted.
- reset asserted mid-WRITE after 2 of 8 bytes -> every output at its reset value the next cycle; only the 2 written bytes are modified in RAM.

Source files
------------

// File: rtl/wram_arbiter.sv
// Work-RAM arbiter: shares one single-port byte-wide BRAM between the console
// (absolute priority, never stalled) and a host DMA engine doing block bursts.
// Ports: console side (cpu_en, con_req/con_write/con_addr/con_wdata -> con_rdata),
//        host burst command (host_start/dir/addr/len/abort -> host_busy/done),
//        host write stream (host_wdata/wvalid/wready), host read stream
//        (host_rdata/rvalid/rready), BRAM side (ram_addr/wdata/wren, ram_q 1-cycle).
module wram_arbiter #(
  parameter int ADDR_W      = 17,
  parameter int RFIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_en,
  input  logic              con_req,
  input  logic              con_write,
  input  logic [ADDR_W-1:0] con_addr,
  input  logic [7:0]        con_wdata,
  output logic [7:0]        con_rdata,
  input  logic              host_start,
  input  logic              host_dir,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [ADDR_W:0]   host_len,
  input  logic              host_abort,
  input  logic [7:0]        host_wdata,
  input  logic              host_wvalid,
  output logic              host_wready,
  output logic [7:0]        host_rdata,
  output logic              host_rvalid,
  input  logic              host_rready,
  output logic              host_busy,
  output logic              host_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_wren,
  input  logic [7:0]        ram_q
);

  localparam int PW = $clog2(RFIFO_DEPTH);
  localparam logic [PW:0] FIFO_FULL = (PW+1)'(RFIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              inflight_q, inflight_d;
  logic [PW:0]       fcnt_q, fcnt_d;
  logic [PW-1:0]     fwr_q, frd_q;
  logic [7:0]        fmem_q [RFIFO_DEPTH];
  logic              con_rd_pend_q;
  logic [7:0]        hold_q;

  logic con_gnt, flush, last, wr_fire, rd_issue, fpush, fpop;

  always_comb begin
    con_gnt    = cpu_en & con_req;
    flush      = host_abort & (state_q != S_IDLE);
    last       = (rem_q == (ADDR_W+1)'(1));
    state_d    = state_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    wr_fire    = 1'b0;
    rd_issue   = 1'b0;
    host_wready = (state_q == S_WRITE) & ~con_gnt;

    case (state_q)
      S_IDLE: begin
        if (host_start) begin
          ptr_d = host_addr;
          rem_d = host_len;
          if (host_len == '0)  state_d = S_DONE;
          else if (host_dir)   state_d = S_READ;
          else                 state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (host_wvalid & host_wready) begin
          wr_fire = 1'b1;
          ptr_d   = ptr_q + ADDR_W'(1);
          rem_d   = rem_q - (ADDR_W+1)'(1);
          if (last) state_d = S_DONE;
        end
      end
      S_READ: begin
        // Only issue when the returning byte is guaranteed a FIFO slot,
        // counting the read still in flight from the previous cycle.
        if (~con_gnt && ((fcnt_q + {{PW{1'b0}}, inflight_q}) < FIFO_FULL)) begin
          rd_issue = 1'b1;
          ptr_d    = ptr_q + ADDR_W'(1);
          rem_d    = rem_q - (ADDR_W+1)'(1);
          if (last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (~inflight_q && (fcnt_q == '0)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (flush) state_d = S_IDLE;

    inflight_d = rd_issue & ~flush;
    fpush      = inflight_q & ~flush;
    fpop       = (fcnt_q != '0) & host_rready & ~flush;
    fcnt_d     = flush ? '0 : fcnt_q + {{PW{1'b0}}, fpush} - {{PW{1'b0}}, fpop};
  end

  // BRAM port mux: console wins outright; host only sees leftover cycles.
  assign ram_addr  = con_gnt ? con_addr  : ptr_q;
  assign ram_wdata = con_gnt ? con_wdata : (wr_fire ? host_wdata : 8'h00);
  assign ram_wren  = con_gnt ? con_write : wr_fire;

  assign host_rvalid = (fcnt_q != '0);
  assign host_rdata  = host_rvalid ? fmem_q[frd_q] : 8'h00;
  assign host_busy   = (state_q == S_WRITE) | (state_q == S_READ) | (state_q == S_DRAIN);
  assign host_done   = (state_q == S_DONE) & ~host_abort;

  // Read data is live from the BRAM in the cycle after a console read,
  // then held so later host traffic on ram_q cannot disturb it.
  assign con_rdata = con_rd_pend_q ? ram_q : hold_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      rem_q         <= '0;
      inflight_q    <= 1'b0;
      fcnt_q        <= '0;
      fwr_q         <= '0;
      frd_q         <= '0;
      con_rd_pend_q <= 1'b0;
      hold_q        <= 8'h00;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      inflight_q <= inflight_d;
      fcnt_q     <= fcnt_d;
      if (flush) begin
        fwr_q <= '0;
        frd_q <= '0;
      end else begin
        if (fpush) begin
          fmem_q[fwr_q] <= ram_q;
          fwr_q         <= fwr_q + PW'(1);
        end
        if (fpop) frd_q <= frd_q + PW'(1);
      end
      con_rd_pend_q <= con_gnt & ~con_write;
      if (con_rd_pend_q) hold_q <= ram_q;
    end
  end

endmodule

// File: tb/tb_wram_arbiter.sv
module tb_wram_arbiter;
  localparam int AW = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, cpu_en, con_req, con_write;
  logic [AW-1:0] con_addr;
  logic [7:0]    con_wdata, con_rdata;
  logic          host_start, host_dir, host_abort;
  logic [AW-1:0] host_addr;
  logic [AW:0]   host_len;
  logic [7:0]    host_wdata, host_rdata;
  logic          host_wvalid, host_wready, host_rvalid, host_rready;
  logic          host_busy, host_done;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata, ram_q;
  logic          ram_wren;

  wram_arbiter #(.ADDR_W(AW), .RFIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .cpu_en(cpu_en), .con_req(con_req),
    .con_write(con_write), .con_addr(con_addr), .con_wdata(con_wdata),
    .con_rdata(con_rdata), .host_start(host_start), .host_dir(host_dir),
    .host_addr(host_addr), .host_len(host_len), .host_abort(host_abort),
    .host_wdata(host_wdata), .host_wvalid(host_wvalid), .host_wready(host_wready),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid), .host_rready(host_rready),
    .host_busy(host_busy), .host_done(host_done), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int rd_pops = 0;
  logic [7:0] rd_q [$];
  logic [7:0] con_q [$];
  logic       con_pend = 1'b0;
  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] wd [4];

  function automatic logic [7:0] pat(input int a);
    return 8'((a * 37 + 11) & 255);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_con_rdata"},   con_rdata, 0);
    check({tag, "_host_wready"}, host_wready, 0);
    check({tag, "_host_rvalid"}, host_rvalid, 0);
    check({tag, "_host_rdata"},  host_rdata, 0);
    check({tag, "_host_busy"},   host_busy, 0);
    check({tag, "_host_done"},   host_done, 0);
    check({tag, "_ram_wren"},    ram_wren, 0);
    check({tag, "_ram_addr"},    ram_addr, 0);
    check({tag, "_ram_wdata"},   ram_wdata, 0);
  endtask

  // BRAM model: registered read, write on wren.
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = pat(i);
    mem[32'h123] = 8'h5A;
    ram_q <= 8'h00;
    forever begin
      @(posedge clk);
      ram_q <= mem[ram_addr];
      if (ram_wren) mem[ram_addr] = ram_wdata;
    end
  end

  // Monitor: read stream, console read data, done pulses.
  always @(negedge clk) begin
    if (host_done) done_cnt++;
    if (host_rvalid && host_rready) begin
      rd_pops++;
      if (rd_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_extra: got %0h with nothing expected", host_rdata);
      end else begin
        check("rd_data", {24'h0, host_rdata}, {24'h0, rd_q.pop_front()});
      end
    end
    if (con_pend) begin
      if (con_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL con_extra: got %0h with nothing expected", con_rdata);
      end else begin
        check("con_rdata", {24'h0, con_rdata}, {24'h0, con_q.pop_front()});
      end
    end
    con_pend = cpu_en & con_req & ~con_write & ~reset;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    int idx, k;
    logic fired, got;
    wd = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    reset = 1'b1; cpu_en = 1'b0; con_req = 1'b0; con_write = 1'b0;
    con_addr = '0; con_wdata = '0; host_start = 1'b0; host_dir = 1'b0;
    host_addr = '0; host_len = '0; host_abort = 1'b0; host_wdata = '0;
    host_wvalid = 1'b0; host_rready = 1'b0;

    // Reset state
    step(); step();
    samp();
    check_reset_outputs("rst");
    step(); reset = 1'b0;

    // Console read with hold
    step(); cpu_en = 1'b1; con_req = 1'b1; con_write = 1'b0; con_addr = 17'h00123;
    con_q.push_back(8'h5A);
    step(); con_req = 1'b0;
    repeat (5) step();
    samp();
    check("con_hold", con_rdata, 8'h5A);

    // Host write burst interleaved with console writes every other cycle
    step(); host_start = 1'b1; host_dir = 1'b0; host_addr = 17'h01000; host_len = 18'd4;
    exp_done++;
    step(); host_start = 1'b0;
    idx = 0; k = 0;
    for (int cyc = 0; cyc < 40 && idx < 4; cyc++) begin
      con_req = (cyc % 2 == 0); con_write = 1'b1;
      con_addr = 17'h00200 + 17'(k); con_wdata = 8'h10 + 8'(k);
      host_wvalid = 1'b1; host_wdata = wd[idx];
      samp();
      check("wr_wready", host_wready, {31'b0, ~con_req});
      check("wr_con_rdata", con_rdata, 8'h5A);
      check("wr_busy", host_busy, 1);
      if (con_req) check("wr_con_addr", ram_addr, con_addr);
      fired = host_wready;
      step();
      if (fired) idx++;
      if (con_req) k++;
    end
    host_wvalid = 1'b0; con_req = 1'b0; con_write = 1'b0;
    samp();
    check("wr_all_fired", idx, 4);
    check("wr_done", host_done, 1);
    for (int j = 0; j < 4; j++) check("wr_mem", mem[32'h1000 + j], wd[j]);
    check("wr_con_count", k, 4);
    for (int j = 0; j < 4; j++) check("wr_con_mem", mem[32'h200 + j], 8'h10 + 8'(j));

    // Host read burst across the top of memory, rready toggling
    step(); cpu_en = 1'b0; host_start = 1'b1; host_dir = 1'b1;
    host_addr = 17'h1FFFE; host_len = 18'd6;
    rd_q.push_back(pat(32'h1FFFE)); rd_q.push_back(pat(32'h1FFFF));
    for (int j = 0; j < 4; j++) rd_q.push_back(pat(j));
    exp_done++;
    step(); host_start = 1'b0;
    got = 1'b0;
    for (int cyc = 0; cyc < 200 && !got; cyc++) begin
      host_rready = (cyc % 2 == 0);
      samp();
      got = host_done;
      step();
    end
    host_rready = 1'b0;
    check("rd_done_seen", got, 1);
    check("rd_all_returned", rd_q.size(), 0);
    check("rd_pop_count", rd_pops, 6);

    // Zero-length burst
    step(); host_start = 1'b1; host_dir = 1'b0; host_addr = 17'h00600; host_len = '0;
    samp();
    check("z_busy0", host_busy, 0);
    check("z_wren0", ram_wren, 0);
    step(); host_start = 1'b0;
    exp_done++;
    samp();
    check("z_done", host_done, 1);
    check("z_busy1", host_busy, 0);
    check("z_wren1", ram_wren, 0);
    step();
    samp();
    check("z_done_once", host_done, 0);
    check("z_mem", mem[32'h600], pat(32'h600));

    // Abort in READ with one entry buffered and one read in flight
    step(); host_start = 1'b1; host_dir = 1'b1; host_addr = 17'h00300; host_len = 18'd8;
    host_rready = 1'b0;
    step(); host_start = 1'b0;
    step();
    step(); host_abort = 1'b1;
    samp();
    check("ab_rvalid_pre", host_rvalid, 1);
    check("ab_rdata_pre", host_rdata, pat(32'h300));
    check("ab_busy_pre", host_busy, 1);
    step(); host_abort = 1'b0;
    samp();
    check("ab_rvalid", host_rvalid, 0);
    check("ab_busy", host_busy, 0);
    check("ab_no_done", host_done, 0);
    step();
    samp();
    check("ab_rvalid_late", host_rvalid, 0);
    step(); host_start = 1'b1; host_dir = 1'b0; host_addr = 17'h00400; host_len = 18'd1;
    host_wvalid = 1'b1; host_wdata = 8'h77;
    step(); host_start = 1'b0;
    exp_done++;
    samp();
    check("ab_restart_busy", host_busy, 1);
    check("ab_restart_wready", host_wready, 1);
    step(); host_wvalid = 1'b0;
    samp();
    check("ab_restart_done", host_done, 1);
    check("ab_restart_mem", mem[32'h400], 8'h77);

    // Reset mid-write after two of eight bytes
    step(); host_start = 1'b1; host_dir = 1'b0; host_addr = 17'h00500; host_len = 18'd8;
    host_wvalid = 1'b1; host_wdata = 8'h80;
    step(); host_start = 1'b0;
    step(); host_wdata = 8'h81;
    step(); host_wvalid = 1'b0; reset = 1'b1;
    step(); reset = 1'b0;
    samp();
    check_reset_outputs("mid");
    check("mid_mem0", mem[32'h500], 8'h80);
    check("mid_mem1", mem[32'h501], 8'h81);
    for (int j = 2; j < 8; j++) check("mid_mem_untouched", mem[32'h500 + j], pat(32'h500 + j));
    repeat (2) step();

    check("done_count", done_cnt, exp_done);
    check("con_all_checked", con_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
